// File: rtl/spi_apb_bridge.sv
// APB slave front end that fans one APB target out to NUM_PORTS register ports,
// with address/privilege decode, per-transfer timeout, protocol checking and sticky error capture.
module spi_apb_bridge #(
    parameter int unsigned                APB_DATA_WIDTH = 32,
    parameter int unsigned                APB_ADDR_WIDTH = 32,
    parameter int unsigned                NUM_PORTS      = 4,
    parameter int unsigned                PORT_ADDR_BITS = 8,
    parameter logic [APB_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter logic [NUM_PORTS-1:0]       PRIV_MASK      = '0,
    parameter int unsigned                TIMEOUT_CYCLE  = 64
) (
    input  logic                                apb_clk_in,
    input  logic                                apb_rstn_in,
    input  logic [APB_ADDR_WIDTH-1:0]           apb_addr_in,
    input  logic                                apb_psel_in,
    input  logic                                apb_penable_in,
    input  logic                                apb_write_in,
    input  logic [APB_DATA_WIDTH-1:0]           apb_wdata_in,
    input  logic [APB_DATA_WIDTH/8-1:0]         apb_strb_in,
    input  logic [2:0]                          apb_prot_in,
    output logic [APB_DATA_WIDTH-1:0]           apb_rdata_out,
    output logic                                apb_ready_out,
    output logic                                apb_slverr_out,
    output logic [NUM_PORTS-1:0]                other_sel_out,
    output logic [PORT_ADDR_BITS-1:0]           other_addr_out,
    output logic                                other_write_out,
    output logic [APB_DATA_WIDTH-1:0]           other_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0]         other_strb_out,
    output logic [2:0]                          other_prot_out,
    input  logic [NUM_PORTS*APB_DATA_WIDTH-1:0] other_rdata_in,
    input  logic [NUM_PORTS-1:0]                other_ready_in,
    input  logic [NUM_PORTS-1:0]                other_error_in,
    input  logic                                err_clr_in,
    output logic [1:0]                          last_err_code_out,
    output logic [APB_ADDR_WIDTH-1:0]           last_err_addr_out,
    output logic [7:0]                          err_count_out,
    output logic [1:0]                          dbg_state_out
);
    localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYCLE + 1);
    localparam int unsigned UPPER_LSB = PORT_ADDR_BITS + IDX_W;
    localparam int unsigned SW        = APB_DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLE - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_e;

    state_e                     state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                       write_q, write_d;
    logic [APB_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]              strb_q, strb_d;
    logic [2:0]                 prot_q, prot_d;
    logic                       dec_err_q, dec_err_d;
    logic [NUM_PORTS-1:0]       sel_q, sel_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [APB_DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                       ready_q, ready_d;
    logic                       slverr_q, slverr_d;
    logic [1:0]                 err_code_q, err_code_d;
    logic [APB_ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
    logic [7:0]                 err_cnt_q, err_cnt_d;

    logic [IDX_W-1:0]           idx_w;
    logic [APB_ADDR_WIDTH-1:0]  upper_diff;
    logic [NUM_PORTS-1:0]       sel_new;
    logic                       priv_bad, dec_err;
    logic                       sel_ready, sel_error, proto_bad;
    logic [APB_DATA_WIDTH-1:0]  sel_rdata;
    logic                       xfer_done, xfer_fail;
    logic [1:0]                 fail_code;

    assign idx_w      = apb_addr_in[PORT_ADDR_BITS +: IDX_W];
    assign upper_diff = (apb_addr_in ^ BASE_ADDR) >> UPPER_LSB;

    // An index that matches no port leaves sel_new empty, which doubles as the out-of-range check.
    always_comb begin
        sel_new  = '0;
        priv_bad = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx_w == IDX_W'(i)) begin
                sel_new[i] = 1'b1;
                priv_bad   = PRIV_MASK[i] & ~apb_prot_in[0];
            end
        end
        dec_err = (|upper_diff) | ~(|sel_new) | priv_bad;
    end

    // Downstream handshake: a port completes the transfer in any cycle where its sel and ready are
    // both high; its error and rdata are sampled in that same cycle, ready/error of other ports are masked.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | other_rdata_in[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        end
        sel_ready = |(sel_q & other_ready_in);
        sel_error = |(sel_q & other_ready_in & other_error_in);
        proto_bad = !apb_psel_in || !apb_penable_in || (apb_addr_in != addr_q) ||
                    (apb_write_in != write_q) || (apb_strb_in != strb_q) ||
                    (apb_prot_in != prot_q) || (write_q && (apb_wdata_in != wdata_q));
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        prot_d     = prot_q;
        dec_err_d  = dec_err_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rdata_d    = '0;
        ready_d    = 1'b0;
        slverr_d   = 1'b0;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        xfer_done  = 1'b0;
        xfer_fail  = 1'b0;
        fail_code  = 2'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (apb_psel_in && !apb_penable_in) begin
                    addr_d    = apb_addr_in;
                    write_d   = apb_write_in;
                    wdata_d   = apb_wdata_in;
                    strb_d    = apb_strb_in;
                    prot_d    = apb_prot_in;
                    dec_err_d = dec_err;
                    sel_d     = dec_err ? '0 : sel_new;
                    cnt_d     = '0;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (proto_bad) begin
                    xfer_done = 1'b1; xfer_fail = 1'b1; fail_code = 2'd3;
                end else if (dec_err_q) begin
                    xfer_done = 1'b1; xfer_fail = 1'b1; fail_code = 2'd1;
                end else if (sel_ready) begin
                    xfer_done = 1'b1;
                    if (sel_error) begin
                        xfer_fail = 1'b1; fail_code = 2'd2;
                    end else if (!write_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (cnt_q == TO_LAST) begin
                    xfer_done = 1'b1; xfer_fail = 1'b1; fail_code = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (xfer_done) begin
                    sel_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b1;
                    slverr_d = xfer_fail;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // A new error in the same cycle as a clear restarts the count at one.
        if (xfer_fail) begin
            err_code_d = fail_code;
            err_addr_d = addr_q;
            err_cnt_d  = err_clr_in ? 8'd1 : ((err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1);
        end else if (err_clr_in) begin
            err_code_d = 2'd0;
            err_addr_d = '0;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            prot_q     <= '0;
            dec_err_q  <= 1'b0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            slverr_q   <= 1'b0;
            err_code_q <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            prot_q     <= prot_d;
            dec_err_q  <= dec_err_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            slverr_q   <= slverr_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign apb_rdata_out     = rdata_q;
    assign apb_ready_out     = ready_q;
    assign apb_slverr_out    = slverr_q;
    assign other_sel_out     = sel_q;
    assign other_addr_out    = addr_q[PORT_ADDR_BITS-1:0];
    assign other_write_out   = write_q;
    assign other_wdata_out   = wdata_q;
    assign other_strb_out    = strb_q;
    assign other_prot_out    = prot_q;
    assign last_err_code_out = err_code_q;
    assign last_err_addr_out = err_addr_q;
    assign err_count_out     = err_cnt_q;
    assign dbg_state_out     = state_q;
endmodule
